// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the execute stage and the data-memory port.
// Accepts one request at a time, derives byte lanes and lane-aligned store data,
// runs the memory handshake with an optional wait-state timeout and returns
// sign/zero-extended load data or an error response.
//
// Parameters
//   XLEN      datapath width, 32 or 64 (NB = XLEN/8 lanes, OW = log2(NB))
//   ADDR_W    address width
//   MAX_WAIT  max ACCESS cycles without d_ack_i before timing out; 0 = no timeout
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   req_valid_i / req_ready_o      request handshake (ready only in IDLE)
//   mem_write_i, funct3_i          store/load and RISC-V size/signedness
//   addr_i, wdata_i                byte address, right-justified store data
//   rsp_valid_o, rdata_o           one-cycle response pulse and extended load data
//   err_o, err_cause_o             error flag; 01 misaligned, 10 illegal, 11 timeout
//   d_req_o, d_addr_o, d_we_o,
//   d_wdata_o                      memory request, aligned address, lanes, lane data
//   d_ack_i, d_rdata_i             memory completion and full aligned read word
//
// state  | meaning
// IDLE   | ready for a request; decode and either start an access or flag an error
// ACCESS | d_req_o held high until d_ack_i or the wait counter expires
// RESP   | rsp_valid_o high for one cycle, then back to IDLE
module lsu_ctrl #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              err_o,
  output logic [1:0]        err_cause_o,
  output logic              d_req_o,
  output logic [ADDR_W-1:0] d_addr_o,
  output logic [XLEN/8-1:0] d_we_o,
  output logic [XLEN-1:0]   d_wdata_o,
  input  logic              d_ack_i,
  input  logic [XLEN-1:0]   d_rdata_i
);

  localparam int NB     = XLEN / 8;
  localparam int OW     = $clog2(NB);
  localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = (MAX_WAIT > 0) ? WCNT_W'(MAX_WAIT - 1) : '0;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              write_q;
  logic [OW-1:0]     off_q;
  logic [WCNT_W-1:0] wait_cnt;

  // request decode, straight from the input ports
  logic [1:0]      req_size;
  logic [OW-1:0]   req_off;
  logic            illegal;
  logic            misaligned;
  logic [NB-1:0]   size_mask;
  logic [NB-1:0]   we_next;
  logic [XLEN-1:0] wdata_next;
  logic            is_xlen32;

  assign req_size  = funct3_i[1:0];
  assign req_off   = addr_i[OW-1:0];
  assign is_xlen32 = (XLEN == 32);

  assign illegal = (req_size == 2'd3 && is_xlen32)
                || (mem_write_i && funct3_i[2])
                || (!mem_write_i && funct3_i == 3'b111)
                || (!mem_write_i && funct3_i == 3'b110 && is_xlen32);

  always_comb begin
    misaligned = 1'b0;
    size_mask  = '0;
    case (req_size)
      2'd0: begin misaligned = 1'b0;                  size_mask = NB'(8'h01); end
      2'd1: begin misaligned = addr_i[0] != 1'b0;     size_mask = NB'(8'h03); end
      2'd2: begin misaligned = addr_i[1:0] != 2'b00;  size_mask = NB'(8'h0F); end
      default: begin misaligned = addr_i[2:0] != 3'b000; size_mask = NB'(8'hFF); end
    endcase
  end

  assign we_next    = size_mask << req_off;
  assign wdata_next = wdata_i << {req_off, 3'b000};

  // load extraction uses the offset/size captured at accept time
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;

  assign shifted = d_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_ext = '0;
    case (size_q)
      2'd0: begin
        if (unsigned_q) load_ext[7:0] = shifted[7:0];
        else            load_ext = XLEN'($signed(shifted[7:0]));
      end
      2'd1: begin
        if (unsigned_q) load_ext[15:0] = shifted[15:0];
        else            load_ext = XLEN'($signed(shifted[15:0]));
      end
      2'd2: begin
        if (unsigned_q) load_ext[31:0] = shifted[31:0];
        else            load_ext = XLEN'($signed(shifted[31:0]));
      end
      default: load_ext = shifted;
    endcase
  end

  // ack wins over an expiring counter in the same cycle
  logic timeout;
  assign timeout = (MAX_WAIT > 0) && (wait_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      err_cause_o <= CAUSE_NONE;
      d_req_o     <= 1'b0;
      d_addr_o    <= '0;
      d_we_o      <= '0;
      d_wdata_o   <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      write_q     <= 1'b0;
      off_q       <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            size_q      <= req_size;
            unsigned_q  <= funct3_i[2];
            write_q     <= mem_write_i;
            off_q       <= req_off;
            if (illegal || misaligned) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              err_o       <= 1'b1;
              err_cause_o <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALGN;
              rdata_o     <= '0;
            end else begin
              state     <= S_ACCESS;
              d_req_o   <= 1'b1;
              d_addr_o  <= {addr_i[ADDR_W-1:OW], OW'(0)};
              d_we_o    <= mem_write_i ? we_next : '0;
              d_wdata_o <= mem_write_i ? wdata_next : '0;
              wait_cnt  <= WAIT_LOAD;
            end
          end
        end
        S_ACCESS: begin
          if (d_ack_i) begin
            state       <= S_RESP;
            d_req_o     <= 1'b0;
            rsp_valid_o <= 1'b1;
            err_o       <= 1'b0;
            err_cause_o <= CAUSE_NONE;
            rdata_o     <= write_q ? '0 : load_ext;
          end else if (timeout) begin
            state       <= S_RESP;
            d_req_o     <= 1'b0;
            rsp_valid_o <= 1'b1;
            err_o       <= 1'b1;
            err_cause_o <= CAUSE_TIMEOUT;
            rdata_o     <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          err_o       <= 1'b0;
          err_cause_o <= CAUSE_NONE;
          rdata_o     <= '0;
        end
        default: begin
          state       <= S_IDLE;
          req_ready_o <= 1'b1;
          d_req_o     <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
